// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and muldiv_unit.
// MULDIV_DIVZERO_FLAG_EN adds the divZero_o result flag.
interface muldiv_unit_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic             op_i;
    logic [WIDTH-1:0] opA_i;
    logic [WIDTH-1:0] opB_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] resultLo_o;
    logic [WIDTH-1:0] resultHi_o;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic             divZero_o;

    modport master (
        output start_i, op_i, opA_i, opB_i, flush_i,
        input  busy_o, done_o, resultLo_o, resultHi_o, divZero_o
    );
    modport slave (
        input  start_i, op_i, opA_i, opB_i, flush_i,
        output busy_o, done_o, resultLo_o, resultHi_o, divZero_o
    );
`else
    modport master (
        output start_i, op_i, opA_i, opB_i, flush_i,
        input  busy_o, done_o, resultLo_o, resultHi_o
    );
    modport slave (
        input  start_i, op_i, opA_i, opB_i, flush_i,
        output busy_o, done_o, resultLo_o, resultHi_o
    );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Optional MULDIV_DIVZERO_FLAG_EN drives a divide-by-zero flag alongside done.
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic             op_q, op_d;
    logic             sA_q, sA_d;
    logic             sB_q, sB_d;
    logic             bz_q, bz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] resLo_q, resLo_d;
    logic [WIDTH-1:0] resHi_q, resHi_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTrial;
    logic [2*WIDTH-1:0] prodNeg;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        op_d    = op_q;
        sA_d    = sA_q;
        sB_d    = sB_q;
        bz_d    = bz_q;
        done_d  = 1'b0;
        resLo_d = resLo_q;
        resHi_d = resHi_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        magA     = bus.opA_i[WIDTH-1] ? ('0 - bus.opA_i) : bus.opA_i;
        magB     = bus.opB_i[WIDTH-1] ? ('0 - bus.opB_i) : bus.opB_i;
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : '0);
        divTrial = {hi_q, lo_q[WIDTH-1]} - {1'b0, mb_q};
        prodNeg  = '0 - {hi_q, lo_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    state_d = S_CALC;
                    count_d = '0;
                    op_d    = bus.op_i;
                    sA_d    = bus.opA_i[WIDTH-1];
                    sB_d    = bus.opB_i[WIDTH-1];
                    bz_d    = (bus.opB_i == '0);
                    ma_d    = magA;
                    mb_d    = magB;
                    hi_d    = '0;
                    // lo holds the multiplier for mul, the dividend/quotient for div
                    lo_d    = bus.op_i ? magA : magB;
`ifdef MULDIV_DIVZERO_FLAG_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            S_CALC: begin
                if (op_q) begin
                    if (!divTrial[WIDTH]) begin
                        hi_d = divTrial[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mulSum[WIDTH:1];
                    lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
                if (bus.flush_i) state_d = S_IDLE;
            end
            S_FIX: begin
                if (op_q) begin
                    // a zero divisor leaves the all-ones quotient unsigned;
                    // the remainder fix then restores the original dividend
                    lo_d = ((sA_q ^ sB_q) && !bz_q) ? ('0 - lo_q) : lo_q;
                    hi_d = sA_q ? ('0 - hi_q) : hi_q;
                end else if (sA_q ^ sB_q) begin
                    {hi_d, lo_d} = prodNeg;
                end
                state_d = bus.flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                resLo_d = lo_q;
                resHi_d = hi_q;
                done_d  = 1'b1;
`ifdef MULDIV_DIVZERO_FLAG_EN
                dz_d    = op_q & bz_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            op_q    <= 1'b0;
            sA_q    <= 1'b0;
            sB_q    <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
            resLo_q <= '0;
            resHi_q <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            op_q    <= op_d;
            sA_q    <= sA_d;
            sB_q    <= sB_d;
            bz_q    <= bz_d;
            done_q  <= done_d;
            resLo_q <= resLo_d;
            resHi_q <= resHi_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.busy_o     = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done_o     = done_q;
    assign bus.resultLo_o = resLo_q;
    assign bus.resultHi_o = resHi_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign bus.divZero_o  = dz_q;
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of mul/div results plus hand sequences
// for ignored start, flush, and asynchronous reset mid-operation.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(16)) bif ();

    muldiv_unit #(.WIDTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
    } vec_t;

    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic op, input logic [15:0] a, input logic [15:0] b);
        bif.start_i = 1'b1;
        bif.op_i    = op;
        bif.opA_i   = a;
        bif.opB_i   = b;
        @(posedge clk);
        #1;
        bif.start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bif.done_o && cyc == 0) cyc = i;
            if (cyc != 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int dones;

        vecs[0]  = '{1'b0, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0};
        vecs[1]  = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
        vecs[4]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1};
        vecs[6]  = '{1'b0, 16'h0123, 16'h0045, 16'h4E6F, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
        vecs[8]  = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
        vecs[9]  = '{1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1};
        vecs[10] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b0};
        vecs[12] = '{1'b0, 16'h8000, 16'h0001, 16'h8000, 16'hFFFF, 1'b0};

        rst         = 1'b1;
        bif.start_i = 1'b0;
        bif.op_i    = 1'b0;
        bif.opA_i   = '0;
        bif.opB_i   = '0;
        bif.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bif.busy_o), 32'd0);
        check("reset done", 32'(bif.done_o), 32'd0);
        check("reset lo", 32'(bif.resultLo_o), 32'h0);
        check("reset hi", 32'(bif.resultHi_o), 32'h0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        check("reset divZero", 32'(bif.divZero_o), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 13; v++) begin
            start_op(vecs[v].op, vecs[v].a, vecs[v].b);
            check($sformatf("v%0d busy", v), 32'(bif.busy_o), 32'd1);
            wait_done(cyc);
            check($sformatf("v%0d latency", v), 32'(cyc), 32'd18);
            check($sformatf("v%0d lo", v), 32'(bif.resultLo_o), 32'(vecs[v].lo));
            check($sformatf("v%0d hi", v), 32'(bif.resultHi_o), 32'(vecs[v].hi));
`ifdef MULDIV_DIVZERO_FLAG_EN
            check($sformatf("v%0d divZero", v), 32'(bif.divZero_o), 32'(vecs[v].dz));
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", v), 32'(bif.done_o), 32'd0);
            check($sformatf("v%0d lo hold", v), 32'(bif.resultLo_o), 32'(vecs[v].lo));
        end

        // Second start during the multiply is dropped.
        start_op(1'b0, 16'h0003, 16'h0005);
        cyc   = 0;
        dones = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bif.done_o) begin
                dones++;
                if (cyc == 0) cyc = i;
            end
            if (i == 4) begin
                bif.start_i = 1'b1;
                bif.op_i    = 1'b1;
                bif.opA_i   = 16'h0064;
                bif.opB_i   = 16'h0007;
            end
            if (i == 5) bif.start_i = 1'b0;
        end
        check("ignore-start latency", 32'(cyc), 32'd18);
        check("ignore-start done count", 32'(dones), 32'd1);
        check("ignore-start lo", 32'(bif.resultLo_o), 32'h000F);
        check("ignore-start hi", 32'(bif.resultHi_o), 32'h0000);

        // Flush while in DONE still produces the pulse.
        start_op(1'b0, 16'h0002, 16'h0003);
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 17) bif.flush_i = 1'b1;
            if (i == 18) begin
                bif.flush_i = 1'b0;
                check("flush-in-done done", 32'(bif.done_o), 32'd1);
                check("flush-in-done lo", 32'(bif.resultLo_o), 32'h0006);
            end
        end
        @(posedge clk);
        #1;

        // Flush mid-divide: abort without done, results keep 6/0.
        start_op(1'b1, 16'h0064, 16'h0007);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i == 8) begin
                check("flush pre busy", 32'(bif.busy_o), 32'd1);
                bif.flush_i = 1'b1;
            end
            if (i == 9) begin
                check("flush busy drop", 32'(bif.busy_o), 32'd0);
                bif.flush_i = 1'b0;
            end
        end
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bif.done_o) dones++;
        end
        check("flush no done", 32'(dones), 32'd0);
        check("flush lo kept", 32'(bif.resultLo_o), 32'h0006);
        check("flush hi kept", 32'(bif.resultHi_o), 32'h0000);

        // Flush and start together in IDLE: start loses.
        bif.start_i = 1'b1;
        bif.flush_i = 1'b1;
        bif.op_i    = 1'b0;
        bif.opA_i   = 16'h0009;
        bif.opB_i   = 16'h0009;
        @(posedge clk);
        #1;
        bif.start_i = 1'b0;
        bif.flush_i = 1'b0;
        check("flush+start busy", 32'(bif.busy_o), 32'd0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bif.done_o) dones++;
        end
        check("flush+start no done", 32'(dones), 32'd0);
        check("flush+start lo", 32'(bif.resultLo_o), 32'h0006);

        // Asynchronous reset mid-multiply clears outputs immediately.
        start_op(1'b0, 16'h0011, 16'h0022);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst busy", 32'(bif.busy_o), 32'd0);
        check("rst done", 32'(bif.done_o), 32'd0);
        check("rst lo", 32'(bif.resultLo_o), 32'h0);
        check("rst hi", 32'(bif.resultHi_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bif.done_o) dones++;
        end
        check("rst no done", 32'(dones), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
